// File: rtl/cache_flush_seq.sv
// Whole-cache flush sequencer: D-cache clean+invalidate walk, writeback
// drain, then I-cache invalidate walk, with fetch/LSU stalls while active.
module cache_flush_seq #(
  parameter int IC_SETS = 64,
  parameter int DC_SETS = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ic_flush_req,
  input  logic             dc_flush_req,
  output logic             dc_cmd_valid,
  input  logic             dc_cmd_ready,
  output logic [IDX_W-1:0] dc_cmd_idx,
  input  logic             dc_wb_busy,
  output logic             ic_cmd_valid,
  input  logic             ic_cmd_ready,
  output logic [IDX_W-1:0] ic_cmd_idx,
  output logic             fetch_stall,
  output logic             mem_stall,
  output logic             busy,
  output logic             ic_flush_done,
  output logic             dc_flush_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DC_WALK  = 2'd1,
    DC_DRAIN = 2'd2,
    IC_WALK  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] DC_LAST = IDX_W'(DC_SETS - 1);
  localparam logic [IDX_W-1:0] IC_LAST = IDX_W'(IC_SETS - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             ic_pend, ic_pend_n;
  logic             dc_pend, dc_pend_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      ic_pend <= 1'b0;
      dc_pend <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      ic_pend <= ic_pend_n;
      dc_pend <= dc_pend_n;
    end
  end

  // A request arriving in the same cycle a pend bit is consumed re-arms it.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    ic_pend_n = ic_pend | ic_flush_req;
    dc_pend_n = dc_pend | dc_flush_req;
    unique case (state)
      IDLE: begin
        if (dc_pend) begin
          state_n   = DC_WALK;
          idx_n     = '0;
          dc_pend_n = dc_flush_req;
        end else if (ic_pend) begin
          state_n   = IC_WALK;
          idx_n     = '0;
          ic_pend_n = ic_flush_req;
        end
      end
      DC_WALK: begin
        if (dc_cmd_ready) begin
          if (idx == DC_LAST) begin
            state_n = DC_DRAIN;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      DC_DRAIN: begin
        if (!dc_wb_busy) begin
          idx_n = '0;
          if (ic_pend) begin
            state_n   = IC_WALK;
            ic_pend_n = ic_flush_req;
          end else begin
            state_n = IDLE;
          end
        end
      end
      IC_WALK: begin
        if (ic_cmd_ready) begin
          if (idx == IC_LAST) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_comb begin
    dc_cmd_valid  = 1'b0;
    dc_cmd_idx    = '0;
    ic_cmd_valid  = 1'b0;
    ic_cmd_idx    = '0;
    dc_flush_done = 1'b0;
    ic_flush_done = 1'b0;
    unique case (state)
      DC_WALK: begin
        dc_cmd_valid = 1'b1;
        dc_cmd_idx   = idx;
      end
      DC_DRAIN: begin
        dc_flush_done = !dc_wb_busy;
      end
      IC_WALK: begin
        ic_cmd_valid  = 1'b1;
        ic_cmd_idx    = idx;
        ic_flush_done = ic_cmd_ready && (idx == IC_LAST);
      end
      default: ;
    endcase
  end

  assign mem_stall   = (state == DC_WALK) || (state == DC_DRAIN) || dc_pend;
  assign fetch_stall = (state != IDLE) || ic_pend || dc_pend;
  assign busy        = (state != IDLE) || ic_pend || dc_pend;

endmodule
